// File: rtl/fwd_pkg.sv
// Shared select-code helpers and FSM state encodings for the ID-stage forwarding/hazard unit.
package fwd_pkg;

    localparam int SEL_RF = 0;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    function automatic int sel_w(input int fwd_stages);
        return $clog2(fwd_stages + 2);
    endfunction

    function automatic int sel_stg(input int k);
        return k + 1;
    endfunction

    function automatic int sel_lw(input int fwd_stages);
        return fwd_stages + 1;
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// One source operand: youngest-first stage compare, then long-latency bus, then RF.
module fwd_operand_mux
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int FWD_STAGES = 2,
    parameter int SELW       = 2
) (
    input  logic                       used,
    input  logic [AW-1:0]              addr,
    input  logic [XLEN-1:0]            rf_data,
    input  logic [FWD_STAGES-1:0]      stg_wb_en,
    input  logic [FWD_STAGES*AW-1:0]   stg_dest,
    input  logic [FWD_STAGES*XLEN-1:0] stg_result,
    input  logic [FWD_STAGES-1:0]      stg_ready,
    input  logic                       lw_valid,
    input  logic [AW-1:0]              lw_dest,
    input  logic [XLEN-1:0]            lw_data,
    output logic [XLEN-1:0]            data,
    output logic [SELW-1:0]            sel,
    output logic                       not_ready
);

    logic hit;

    always_comb begin
        data      = rf_data;
        sel       = SELW'(SEL_RF);
        not_ready = 1'b0;
        hit       = 1'b0;
        if (used && addr != '0) begin
            // First matching stage wins; its readiness alone decides load-use.
            for (int k = 0; k < FWD_STAGES; k++) begin
                if (!hit && stg_wb_en[k] && stg_dest[k*AW +: AW] == addr) begin
                    hit       = 1'b1;
                    data      = stg_result[k*XLEN +: XLEN];
                    sel       = SELW'(sel_stg(k));
                    not_ready = ~stg_ready[k];
                end
            end
            if (!hit && lw_valid && lw_dest == addr) begin
                data = lw_data;
                sel  = SELW'(sel_lw(FWD_STAGES));
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// ID-stage forwarding and hazard unit: operand muxes, pending-write scoreboard,
// RUN/STALL tracker and saturating stall counter.
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 16,
    localparam int SELW      = sel_w(FWD_STAGES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [NUM_SRC*AW-1:0]      id_src_addr,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [NUM_SRC*XLEN-1:0]    id_rf_data,
    input  logic                       id_wb_en,
    input  logic [AW-1:0]              id_dest,
    input  logic                       id_long_op,
    input  logic                       flush,
    input  logic [FWD_STAGES-1:0]      stg_wb_en,
    input  logic [FWD_STAGES*AW-1:0]   stg_dest,
    input  logic [FWD_STAGES*XLEN-1:0] stg_result,
    input  logic [FWD_STAGES-1:0]      stg_ready,
    input  logic                       lw_valid,
    input  logic [AW-1:0]              lw_dest,
    input  logic [XLEN-1:0]            lw_data,
    output logic [NUM_SRC*XLEN-1:0]    src_data,
    output logic [NUM_SRC*SELW-1:0]    src_sel,
    output logic                       stall,
    output logic                       id_issue,
    output logic                       busy,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0]    pending_q, pending_d;
    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC-1:0] not_ready;
    logic [NUM_SRC-1:0] pend_hit;
    logic               waw;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        logic [AW-1:0] addr;
        assign addr = id_src_addr[j*AW +: AW];

        fwd_operand_mux #(
            .XLEN       (XLEN),
            .AW         (AW),
            .FWD_STAGES (FWD_STAGES),
            .SELW       (SELW)
        ) u_mux (
            .used       (id_src_used[j]),
            .addr       (addr),
            .rf_data    (id_rf_data[j*XLEN +: XLEN]),
            .stg_wb_en  (stg_wb_en),
            .stg_dest   (stg_dest),
            .stg_result (stg_result),
            .stg_ready  (stg_ready),
            .lw_valid   (lw_valid),
            .lw_dest    (lw_dest),
            .lw_data    (lw_data),
            .data       (src_data[j*XLEN +: XLEN]),
            .sel        (src_sel[j*SELW +: SELW]),
            .not_ready  (not_ready[j])
        );

        // A pending source is satisfied by the bus writing it back this very cycle.
        assign pend_hit[j] = id_src_used[j] && addr != '0 && pending_q[addr]
                             && !(lw_valid && lw_dest == addr);
    end

    assign waw = id_long_op && id_wb_en && id_dest != '0 && pending_q[id_dest]
                 && !(lw_valid && lw_dest == id_dest);

    assign stall     = id_valid && !flush && (|not_ready || |pend_hit || waw);
    assign id_issue  = id_valid && !stall && !flush;
    assign busy      = |pending_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        pending_d = pending_q;
        if (lw_valid) begin
            pending_d[lw_dest] = 1'b0;
        end
        // Applied after the clear so a same-register set wins.
        if (id_issue && id_long_op && id_wb_en && id_dest != '0) begin
            pending_d[id_dest] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stall)  state_d = ST_STALL;
            ST_STALL: if (!stall) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: vector table, directed multi-cycle sequences,
// and randomized traffic against an array-based reference model.
module tb_fwd_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [63:0] id_rf_data;
    logic        id_wb_en;
    logic [4:0]  id_dest;
    logic        id_long_op;
    logic        flush;
    logic [1:0]  stg_wb_en;
    logic [9:0]  stg_dest;
    logic [63:0] stg_result;
    logic [1:0]  stg_ready;
    logic        lw_valid;
    logic [4:0]  lw_dest;
    logic [31:0] lw_data;
    logic [63:0] src_data;
    logic [3:0]  src_sel;
    logic        stall;
    logic        id_issue;
    logic        busy;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_rf_data  (id_rf_data),
        .id_wb_en    (id_wb_en),
        .id_dest     (id_dest),
        .id_long_op  (id_long_op),
        .flush       (flush),
        .stg_wb_en   (stg_wb_en),
        .stg_dest    (stg_dest),
        .stg_result  (stg_result),
        .stg_ready   (stg_ready),
        .lw_valid    (lw_valid),
        .lw_dest     (lw_dest),
        .lw_data     (lw_data),
        .src_data    (src_data),
        .src_sel     (src_sel),
        .stall       (stall),
        .id_issue    (id_issue),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state: which registers await a long-latency result, and stall count.
    bit          mpend[32];
    int          mcnt;
    logic [31:0] m_data[2];
    int          m_sel[2];
    bit          m_stall;
    bit          m_issue;

    typedef struct {
        logic [9:0]  src_addr;
        logic [1:0]  used;
        logic [63:0] rf;
        logic [1:0]  swb;
        logic [9:0]  sdest;
        logic [63:0] sres;
        logic [1:0]  srdy;
        logic        lwv;
        logic [4:0]  lwd;
        logic [31:0] lwdata;
        logic        vld;
        logic        fl;
        logic [63:0] e_data;
        logic [3:0]  e_sel;
        logic        e_stall;
        logic        e_issue;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_src_addr = '0;
        id_src_used = '0;
        id_rf_data  = '0;
        id_wb_en    = 1'b0;
        id_dest     = '0;
        id_long_op  = 1'b0;
        flush       = 1'b0;
        stg_wb_en   = '0;
        stg_dest    = '0;
        stg_result  = '0;
        stg_ready   = '1;
        lw_valid    = 1'b0;
        lw_dest     = '0;
        lw_data     = '0;
    endtask

    task automatic model_eval();
        bit       hz;
        bit       found;
        bit [4:0] a;
        hz = 0;
        for (int j = 0; j < 2; j++) begin
            a        = id_src_addr[j*5 +: 5];
            m_data[j] = id_rf_data[j*32 +: 32];
            m_sel[j]  = 0;
            if (id_src_used[j] && a != 0) begin
                found = 0;
                for (int k = 0; k < 2; k++) begin
                    if (!found && stg_wb_en[k] && stg_dest[k*5 +: 5] == a) begin
                        found     = 1;
                        m_data[j] = stg_result[k*32 +: 32];
                        m_sel[j]  = k + 1;
                        if (!stg_ready[k]) hz = 1;
                    end
                end
                if (!found && lw_valid && lw_dest == a) begin
                    m_data[j] = lw_data;
                    m_sel[j]  = 3;
                end
                if (mpend[a] && !(lw_valid && lw_dest == a)) hz = 1;
            end
        end
        if (id_long_op && id_wb_en && mpend[id_dest] && !(lw_valid && lw_dest == id_dest)) hz = 1;
        m_stall = id_valid && !flush && hz;
        m_issue = id_valid && !flush && !m_stall;
    endtask

    function automatic bit model_busy();
        for (int r = 0; r < 32; r++) if (mpend[r]) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mpend[r] = 0;
        mcnt = 0;
    endtask

    // Advance the model over the coming rising edge, then wait for the next falling edge.
    task automatic tick();
        model_eval();
        if (lw_valid) mpend[lw_dest] = 0;
        if (m_issue && id_long_op && id_wb_en && id_dest != 0) mpend[id_dest] = 1;
        if (m_stall && mcnt < 65535) mcnt++;
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        model_eval();
        chk({tag, ".data0"}, 64'(src_data[31:0]),  64'(m_data[0]));
        chk({tag, ".data1"}, 64'(src_data[63:32]), 64'(m_data[1]));
        chk({tag, ".sel0"},  64'(src_sel[1:0]),    64'(m_sel[0]));
        chk({tag, ".sel1"},  64'(src_sel[3:2]),    64'(m_sel[1]));
        chk({tag, ".stall"}, 64'(stall),           64'(m_stall));
        chk({tag, ".issue"}, 64'(id_issue),        64'(m_issue));
        chk({tag, ".busy"},  64'(busy),            64'(model_busy()));
        chk({tag, ".cnt"},   64'(stall_cnt),       64'(mcnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        vecs[0] = '{{5'd2, 5'd5}, 2'b11, {32'h22, 32'h11}, 2'b11, {5'd5, 5'd5}, {32'hB, 32'hA}, 2'b11,
                    1'b0, 5'd0, 32'h0, 1'b1, 1'b0, {32'h22, 32'hA}, {2'd0, 2'd1}, 1'b0, 1'b1};
        vecs[1] = '{{5'd9, 5'd0}, 2'b11, {32'h9, 32'h100}, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hFF}, 2'b11,
                    1'b0, 5'd0, 32'h0, 1'b1, 1'b0, {32'h9, 32'h100}, {2'd0, 2'd0}, 1'b0, 1'b1};
        vecs[2] = '{{5'd4, 5'd4}, 2'b10, {32'h41, 32'h40}, 2'b10, {5'd4, 5'd0}, {32'h55, 32'h0}, 2'b11,
                    1'b1, 5'd4, 32'h44, 1'b1, 1'b0, {32'h55, 32'h40}, {2'd2, 2'd0}, 1'b0, 1'b1};
        vecs[3] = '{{5'd0, 5'd6}, 2'b01, {32'h0, 32'h60}, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 2'b11,
                    1'b1, 5'd6, 32'h66, 1'b1, 1'b0, {32'h0, 32'h66}, {2'd0, 2'd3}, 1'b0, 1'b1};
        vecs[4] = '{{5'd3, 5'd0}, 2'b10, {32'h30, 32'h0}, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hDEAD}, 2'b10,
                    1'b0, 5'd0, 32'h0, 1'b1, 1'b0, {32'hDEAD, 32'h0}, {2'd1, 2'd0}, 1'b1, 1'b0};
        vecs[5] = '{{5'd3, 5'd0}, 2'b10, {32'h30, 32'h0}, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hDEAD}, 2'b10,
                    1'b0, 5'd0, 32'h0, 1'b1, 1'b1, {32'hDEAD, 32'h0}, {2'd1, 2'd0}, 1'b0, 1'b0};
        vecs[6] = '{{5'd3, 5'd0}, 2'b10, {32'h30, 32'h0}, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hDEAD}, 2'b10,
                    1'b0, 5'd0, 32'h0, 1'b0, 1'b0, {32'hDEAD, 32'h0}, {2'd1, 2'd0}, 1'b0, 1'b0};
        vecs[7] = '{{5'd3, 5'd0}, 2'b00, {32'h30, 32'h0}, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hDEAD}, 2'b10,
                    1'b0, 5'd0, 32'h0, 1'b1, 1'b0, {32'h30, 32'h0}, {2'd0, 2'd0}, 1'b0, 1'b1};
        vecs[8] = '{{5'd0, 5'd3}, 2'b01, {32'h0, 32'h31}, 2'b11, {5'd3, 5'd8}, {32'h33, 32'h88}, 2'b01,
                    1'b0, 5'd0, 32'h0, 1'b1, 1'b0, {32'h0, 32'h33}, {2'd0, 2'd2}, 1'b1, 1'b0};

        idle();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset.stall", 64'(stall), 64'd0);
        chk("reset.busy",  64'(busy),  64'd0);
        chk("reset.cnt",   64'(stall_cnt), 64'd0);
        rst = 1'b0;

        // Load-use on stage 0, then the value arrives from stage 1.
        idle();
        id_valid = 1'b1; id_src_used = 2'b10; id_src_addr = {5'd3, 5'd0};
        stg_wb_en = 2'b01; stg_dest = {5'd0, 5'd3}; stg_ready = 2'b10;
        #1 chk("ldu.stall1", 64'(stall), 64'd1);
        tick();
        chk("ldu.cnt", 64'(stall_cnt), 64'd1);
        stg_wb_en = 2'b10; stg_dest = {5'd3, 5'd0}; stg_result = {32'h77, 32'h0}; stg_ready = 2'b11;
        #1;
        chk("ldu.data1", 64'(src_data[63:32]), 64'h77);
        chk("ldu.sel1",  64'(src_sel[3:2]),    64'd2);
        chk("ldu.stall2", 64'(stall), 64'd0);
        tick();

        for (int i = 0; i < 9; i++) begin
            idle();
            id_src_addr = vecs[i].src_addr; id_src_used = vecs[i].used; id_rf_data = vecs[i].rf;
            stg_wb_en = vecs[i].swb; stg_dest = vecs[i].sdest; stg_result = vecs[i].sres;
            stg_ready = vecs[i].srdy; lw_valid = vecs[i].lwv; lw_dest = vecs[i].lwd;
            lw_data = vecs[i].lwdata; id_valid = vecs[i].vld; flush = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d.data", i),  src_data, vecs[i].e_data);
            chk($sformatf("vec%0d.sel", i),   64'(src_sel), 64'(vecs[i].e_sel));
            chk($sformatf("vec%0d.stall", i), 64'(stall), 64'(vecs[i].e_stall));
            chk($sformatf("vec%0d.issue", i), 64'(id_issue), 64'(vecs[i].e_issue));
            chk($sformatf("vec%0d.busy", i),  64'(busy), 64'd0);
            tick();
        end

        // Long op to r7, three pending-source stalls, then the writeback is forwarded.
        idle();
        id_valid = 1'b1; id_long_op = 1'b1; id_wb_en = 1'b1; id_dest = 5'd7;
        #1 chk("lng.issue", 64'(id_issue), 64'd1);
        tick();
        idle();
        id_valid = 1'b1; id_src_used = 2'b01; id_src_addr = {5'd0, 5'd7};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("lng.stall%0d", c), 64'(stall), 64'd1);
            chk($sformatf("lng.busy%0d", c),  64'(busy),  64'd1);
            tick();
        end
        lw_valid = 1'b1; lw_dest = 5'd7; lw_data = 32'h1234;
        #1;
        chk("lng.stall_lw", 64'(stall), 64'd0);
        chk("lng.sel_lw",   64'(src_sel[1:0]), 64'd3);
        chk("lng.data_lw",  64'(src_data[31:0]), 64'h1234);
        tick();
        idle();
        #1 chk("lng.busy_after", 64'(busy), 64'd0);

        // WAW on r7: stall until the writeback cycle, which both clears and re-sets.
        idle();
        id_valid = 1'b1; id_long_op = 1'b1; id_wb_en = 1'b1; id_dest = 5'd7;
        tick();
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("waw.stall%0d", c), 64'(stall), 64'd1);
            tick();
        end
        lw_valid = 1'b1; lw_dest = 5'd7; lw_data = 32'h55;
        #1;
        chk("waw.stall_lw", 64'(stall), 64'd0);
        chk("waw.issue_lw", 64'(id_issue), 64'd1);
        tick();
        idle();
        #1 chk("waw.still_busy", 64'(busy), 64'd1);
        lw_valid = 1'b1; lw_dest = 5'd7;
        tick();
        idle();
        #1 chk("waw.drained", 64'(busy), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_src_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_src_used = 2'($urandom);
            id_rf_data  = {$urandom, $urandom};
            id_wb_en    = 1'($urandom);
            id_dest     = 5'($urandom_range(0, 7));
            id_long_op  = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            stg_wb_en   = 2'($urandom);
            stg_dest    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            stg_result  = {$urandom, $urandom};
            stg_ready   = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            lw_valid    = ($urandom_range(0, 2) == 0);
            lw_dest     = 5'($urandom_range(0, 7));
            lw_data     = $urandom;
            #1 chk_model($sformatf("rnd%0d", i));
            tick();
        end

        // Forced long pending-source stall to saturate the counter, then async reset mid-stall.
        idle();
        do_reset();
        id_valid = 1'b1; id_long_op = 1'b1; id_wb_en = 1'b1; id_dest = 5'd7;
        tick();
        idle();
        id_valid = 1'b1; id_src_used = 2'b01; id_src_addr = {5'd0, 5'd7};
        for (int c = 0; c < 65540; c++) tick();
        #1;
        chk("sat.cnt",   64'(stall_cnt), 64'hFFFF);
        chk("sat.stall", 64'(stall), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst.stall", 64'(stall), 64'd0);
        chk("arst.busy",  64'(busy),  64'd0);
        chk("arst.cnt",   64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
        #1 chk_model("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
